// File: rtl/pcpi_pkg.sv
// PCPI shared types and constants.
// Used by the initiator, its benches and sibling coprocessors.
package pcpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RESP
  } pcpi_state_e;

  localparam logic [6:0] PCPI_OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] PCPI_FUNCT7_MULDIV = 7'b0000001;
  localparam int         PCPI_LAT_W         = 16;

  typedef struct packed {
    logic                  wr;
    logic [31:0]           rd;
    logic                  illegal;
    logic [PCPI_LAT_W-1:0] latency;
  } pcpi_rsp_t;

endpackage

// File: rtl/pcpi_initiator_if.sv
// Core request, PCPI bus and core response bundle.
// The master modport is the initiator side.
interface pcpi_initiator_if #(
  parameter int LAT_W = 16
);

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_insn;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic             flush;

  logic             pcpi_valid;
  logic [31:0]      pcpi_insn;
  logic [31:0]      pcpi_rs1;
  logic [31:0]      pcpi_rs2;
  logic             pcpi_wr;
  logic [31:0]      pcpi_rd;
  logic             pcpi_wait;
  logic             pcpi_ready;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_wr;
  logic [31:0]      rsp_rd;
  logic             rsp_illegal;
  logic [LAT_W-1:0] rsp_latency;

  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, flush,
    input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  rsp_ready,
    output req_ready,
    output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    output rsp_valid, rsp_wr, rsp_rd, rsp_illegal, rsp_latency
  );

  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, flush,
    output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output rsp_ready,
    input  req_ready,
    input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
    input  rsp_valid, rsp_wr, rsp_rd, rsp_illegal, rsp_latency
  );

endinterface

// File: rtl/pcpi_timeout_ctr.sv
// Loadable up/down counter with clear, enable and terminal count.
// tc is all-ones when counting up, zero when counting down.
module pcpi_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = up ? cnt_q + W'(1) : cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = up ? (&cnt_q) : (cnt_q == '0);

endmodule

// File: rtl/pcpi_initiator.sv
// PCPI initiator: issues one instruction, waits for a result
// or a timeout, and buffers the response for the core.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int LAT_W   = PCPI_LAT_W
) (
  input logic              clk,
  input logic              resetn,
  pcpi_initiator_if.master bus
);

  pcpi_state_e state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic        wr_q, wr_d;
  logic [31:0] rd_q, rd_d;
  logic        ill_q, ill_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic ctr_clr;
  logic ctr_load;
  logic ctr_en;
  logic ctr_tc;

  // Counts down from TIMEOUT-1; reaching zero in ISSUE fires.
  pcpi_timeout_ctr #(
    .W (8)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (resetn),
    .clr      (ctr_clr),
    .load     (ctr_load),
    .load_val (8'(TIMEOUT - 1)),
    .en       (ctr_en),
    .up       (1'b0),
    .tc       (ctr_tc)
  );

  always_comb begin
    state_d  = state_q;
    insn_d   = insn_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    ill_d    = ill_q;
    lat_d    = lat_q;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          insn_d   = bus.req_insn;
          rs1_d    = bus.req_rs1;
          rs2_d    = bus.req_rs2;
          lat_d    = '0;
          ctr_load = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!(&lat_q)) begin
          lat_d = lat_q + LAT_W'(1);
        end
        if (bus.pcpi_ready) begin
          wr_d    = bus.pcpi_wr;
          rd_d    = bus.pcpi_rd;
          ill_d   = 1'b0;
          state_d = ST_RESP;
        end else if (bus.pcpi_wait) begin
          ctr_load = 1'b1;
        end else if (ctr_tc) begin
          wr_d    = 1'b0;
          rd_d    = '0;
          ill_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          ctr_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A request offered in IDLE is new work, not in-flight.
    if (bus.flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      ctr_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      insn_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      insn_q  <= insn_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
      lat_q   <= lat_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE) && resetn;
  assign bus.pcpi_valid  = (state_q == ST_ISSUE);
  assign bus.pcpi_insn   = insn_q;
  assign bus.pcpi_rs1    = rs1_q;
  assign bus.pcpi_rs2    = rs2_q;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_wr      = wr_q;
  assign bus.rsp_rd      = rd_q;
  assign bus.rsp_illegal = ill_q;
  assign bus.rsp_latency = lat_q;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator: directed stimulus with a response
// scoreboard drained by an independent monitor.
module tb_pcpi_initiator;
  import pcpi_pkg::*;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  pcpi_initiator_if #(.LAT_W(PCPI_LAT_W)) bus ();

  pcpi_initiator #(
    .TIMEOUT (16),
    .LAT_W   (PCPI_LAT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  pcpi_rsp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] rd,
                          input logic ill, input int lat);
    pcpi_rsp_t e;
    e.wr      = wr;
    e.rd      = rd;
    e.illegal = ill;
    e.latency = PCPI_LAT_W'(lat);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        chk("rsp_wr", 32'(bus.rsp_wr), 32'(exp_q[0].wr));
        chk("rsp_rd", bus.rsp_rd, exp_q[0].rd);
        chk("rsp_illegal", 32'(bus.rsp_illegal), 32'(exp_q[0].illegal));
        chk("rsp_latency", 32'(bus.rsp_latency), 32'(exp_q[0].latency));
        if (bus.rsp_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Returns in ISSUE cycle 1.
  task automatic issue(input logic [31:0] insn,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_insn  = insn;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    while (!bus.req_ready && n < 50) begin
      n++;
      cyc();
    end
    if (n >= 50) chk("req_ready_timeout", 32'd1, 32'd0);
    cyc();
    bus.req_valid = 1'b0;
    chk("pcpi_valid_t1", 32'(bus.pcpi_valid), 32'd1);
    chk("pcpi_insn", bus.pcpi_insn, insn);
    chk("pcpi_rs1", bus.pcpi_rs1, rs1);
    chk("pcpi_rs2", bus.pcpi_rs2, rs2);
  endtask

  task automatic count_valid(output int n);
    n = 0;
    while (bus.pcpi_valid && n < 200) begin
      n++;
      cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] div_insn;
    int n;
    checks   = 0;
    failures = 0;
    div_insn = {PCPI_FUNCT7_MULDIV, 5'd2, 5'd1, 3'b100, 5'd3,
                PCPI_OPCODE_OP};
    resetn         = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_insn   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.flush      = 1'b0;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = '0;
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.rsp_ready  = 1'b1;

    repeat (3) cyc();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_pcpi_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("rst_pcpi_insn", bus.pcpi_insn, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rd", bus.rsp_rd, 32'd0);
    chk("rst_rsp_latency", 32'(bus.rsp_latency), 32'd0);
    resetn = 1'b1;
    #1;
    chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

    // DIV -7 / 2 with wait from cycle 1 and ready at cycle 35
    issue(div_insn, 32'hFFFF_FFF9, 32'd2);
    bus.pcpi_wait = 1'b1;
    repeat (34) cyc();
    bus.pcpi_wait  = 1'b0;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'hFFFF_FFFD;
    push_exp(1'b1, 32'hFFFF_FFFD, 1'b0, 35);
    cyc();
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr    = 1'b0;
    chk("div_valid_drop", 32'(bus.pcpi_valid), 32'd0);
    chk("div_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    cyc();

    // No responder: illegal after 16 cycles
    push_exp(1'b0, 32'd0, 1'b1, 16);
    issue(32'h0000_000B, 32'h1111_1111, 32'h2222_2222);
    count_valid(n);
    chk("tmo_valid_cycles", 32'(n), 32'd16);
    cyc();

    // Wait pulse on cycle 10 restarts the timeout
    push_exp(1'b0, 32'd0, 1'b1, 26);
    issue(32'h0000_002B, 32'h3, 32'h4);
    repeat (9) cyc();
    bus.pcpi_wait = 1'b1;
    cyc();
    bus.pcpi_wait = 1'b0;
    count_valid(n);
    chk("wait_valid_after", 32'(n), 32'd16);
    cyc();

    // Ready on the timeout cycle wins
    issue(32'h0000_005B, 32'h5, 32'h6);
    repeat (15) cyc();
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b0;
    bus.pcpi_rd    = 32'h1234_5678;
    push_exp(1'b0, 32'h1234_5678, 1'b0, 16);
    cyc();
    bus.pcpi_ready = 1'b0;
    chk("race_valid_drop", 32'(bus.pcpi_valid), 32'd0);
    cyc();

    // Response held while spurious ready strobes arrive
    bus.rsp_ready = 1'b0;
    issue(32'h0000_007B, 32'h7, 32'h8);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'hA5A5_0001;
    push_exp(1'b1, 32'hA5A5_0001, 1'b0, 1);
    cyc();
    bus.pcpi_rd = 32'hDEAD_BEEF;
    bus.pcpi_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.pcpi_ready = (i % 2 == 0);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      cyc();
    end
    bus.pcpi_ready = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_insn   = 32'h0000_00AB;
    chk("drain_req_ready", 32'(bus.req_ready), 32'd0);
    cyc();
    chk("after_drain_ready", 32'(bus.req_ready), 32'd1);
    chk("after_drain_rsp", 32'(bus.rsp_valid), 32'd0);
    cyc();
    bus.req_valid = 1'b0;
    chk("b2b_pcpi_valid", 32'(bus.pcpi_valid), 32'd1);
    chk("b2b_pcpi_insn", bus.pcpi_insn, 32'h0000_00AB);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'h0000_0055;
    push_exp(1'b1, 32'h0000_0055, 1'b0, 1);
    cyc();
    bus.pcpi_ready = 1'b0;
    cyc();

    // Flush in cycle 4 discards a simultaneous ready
    issue(32'h0000_00CB, 32'h9, 32'hA);
    repeat (3) cyc();
    bus.flush      = 1'b1;
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'h99;
    cyc();
    bus.flush      = 1'b0;
    bus.pcpi_ready = 1'b0;
    chk("flush_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("flush_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("flush_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (3) cyc();

    // Reset in cycle 6 of an issue
    issue(32'h0000_00DB, 32'hB, 32'hC);
    repeat (5) cyc();
    resetn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.pcpi_valid), 32'd0);
    chk("arst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("arst_insn", bus.pcpi_insn, 32'd0);
    cyc();
    resetn = 1'b1;
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rel_rsp", 32'(bus.rsp_valid), 32'd0);

    // Recovery after reset
    issue(32'h0000_00EB, 32'hD, 32'hE);
    cyc();
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr    = 1'b1;
    bus.pcpi_rd    = 32'h7;
    push_exp(1'b1, 32'h7, 1'b0, 2);
    cyc();
    bus.pcpi_ready = 1'b0;
    repeat (3) cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
